// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between ID/EX and the HI/LO multiply-divide unit.
// Master drives op requests and hazard info; slave returns status and HI/LO.
interface hilo_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              Start;
  logic [2:0]        Op;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              Flush;
  logic              HiLoRead;
  logic              Busy;
  logic              Stall;
  logic              Done;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output Start, Op, A, B, Flush, HiLoRead,
    input  Busy, Stall, Done, HI, LO
  );

  modport slave (
    input  Start, Op, A, B, Flush, HiLoRead,
    output Busy, Stall, Done, HI, LO
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/DIV unit owning HI/LO: DATA_W+1 cycle latency, MTHI/MTLO single cycle;
// Stall holds upstream while busy. HILO_ACC_EN adds MADD/MSUB accumulate into {HI,LO}.
module hilo_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  hilo_muldiv_unit_if.slave    bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef HILO_ACC_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;
  logic [2*DATA_W:0]   work_q, work_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                div0_q, div0_d;
  logic                is_div_q, is_div_d;
`ifdef HILO_ACC_EN
  logic                acc_q, acc_d;
  logic                sub_q, sub_d;
  logic [2*DATA_W-1:0] acc_sum;
`endif

  logic                accept;
  logic                op_mul, op_div, op_acc, op_signed;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic                busy;

  logic [DATA_W:0]     mul_upper, mul_sum;
  logic [2*DATA_W:0]   mul_next;
  logic [DATA_W:0]     div_shift, div_diff;
  logic [2*DATA_W:0]   div_next;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  // Request decode and operand magnitude for the signed variants.
  always_comb begin
    op_mul = (bus.Op == OP_MULT) || (bus.Op == OP_MULTU);
    op_div = (bus.Op == OP_DIV)  || (bus.Op == OP_DIVU);
`ifdef HILO_ACC_EN
    op_acc = (bus.Op == OP_MADD) || (bus.Op == OP_MSUB);
`else
    op_acc = 1'b0;
`endif
    op_signed = (bus.Op == OP_MULT) || (bus.Op == OP_DIV) || op_acc;
    accept    = (state_q == S_IDLE) && bus.Start && !bus.Flush;
    a_neg     = op_signed && bus.A[DATA_W-1];
    b_neg     = op_signed && bus.B[DATA_W-1];
    abs_a     = a_neg ? -bus.A : bus.A;
    abs_b     = b_neg ? -bus.B : bus.B;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (op_mul || op_acc)) begin
          state_d = S_MUL;
        end else if (accept && op_div) begin
          state_d = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == LAST_STEP) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.Flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // Iteration datapath: shift-add multiply and restoring divide share work_q.
  always_comb begin
    mul_upper = work_q[2*DATA_W:DATA_W];
    mul_sum   = mul_upper + {1'b0, opnd_q};
    mul_next  = {1'b0, (work_q[0] ? mul_sum : mul_upper), work_q[DATA_W-1:1]};

    div_shift = work_q[2*DATA_W-1:DATA_W-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[DATA_W]
              ? {1'b0, div_shift[DATA_W-1:0], work_q[DATA_W-2:0], 1'b0}
              : {1'b0, div_diff[DATA_W-1:0],  work_q[DATA_W-2:0], 1'b1};

    prod_fix  = neg_res_q ? -work_q[2*DATA_W-1:0] : work_q[2*DATA_W-1:0];
    quo_fix   = neg_res_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
    rem_fix   = neg_rem_q ? -work_q[2*DATA_W-1:DATA_W] : work_q[2*DATA_W-1:DATA_W];
`ifdef HILO_ACC_EN
    acc_sum   = sub_q ? ({hi_q, lo_q} - prod_fix) : ({hi_q, lo_q} + prod_fix);
`endif
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    work_d    = work_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
`ifdef HILO_ACC_EN
    acc_d     = acc_q;
    sub_d     = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept && (bus.Op == OP_MTHI)) begin
          hi_d = bus.A;
        end else if (accept && (bus.Op == OP_MTLO)) begin
          lo_d = bus.A;
        end else if (accept && (op_mul || op_div || op_acc)) begin
          // Multiply: multiplier in the low half; divide: dividend in the low half.
          work_d    = {{(DATA_W+1){1'b0}}, (op_div ? abs_a : abs_b)};
          opnd_d    = op_div ? abs_b : abs_a;
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (bus.B == '0);
          is_div_d  = op_div;
`ifdef HILO_ACC_EN
          acc_d     = op_acc;
          sub_d     = bus.Op[0];
`endif
        end
      end
      S_MUL: begin
        work_d = mul_next;
        cnt_d  = cnt_q + CNT_W'(1);
      end
      S_DIV: begin
        work_d = div_next;
        cnt_d  = cnt_q + CNT_W'(1);
      end
      S_FIXUP: begin
        if (!bus.Flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = div0_q ? '1 : quo_fix;
            hi_d = rem_fix;
          end else begin
`ifdef HILO_ACC_EN
            {hi_d, lo_d} = acc_q ? acc_sum : prod_fix;
`else
            {hi_d, lo_d} = prod_fix;
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      work_q    <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
`ifdef HILO_ACC_EN
      acc_q     <= 1'b0;
      sub_q     <= 1'b0;
`endif
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      work_q    <= work_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
`ifdef HILO_ACC_EN
      acc_q     <= acc_d;
      sub_q     <= sub_d;
`endif
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    bus.Busy  = busy;
    bus.Stall = busy && (bus.HiLoRead || bus.Start);
    bus.Done  = done_q;
    bus.HI    = hi_q;
    bus.LO    = lo_q;
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: arithmetic reference model, Done-driven monitor.
module tb_hilo_muldiv_unit;

`ifdef HILO_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  hilo_muldiv_unit_if #(.DATA_W(32)) bus ();
  hilo_muldiv_unit #(.DATA_W(32)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_multi(input logic [2:0] op);
    return (op <= 3'd3) || (ACC && (op >= 3'd6));
  endfunction

  // Architectural result of one op given the current {HI,LO}.
  function automatic logic [63:0] model_exec(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hl);
    logic signed [31:0] sa, sb;
    logic signed [63:0] sp;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    sp = longint'(sa) * longint'(sb);
    case (op)
      3'd0: return sp;
      3'd1: return {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return {a, hl[31:0]};
      3'd5: return {hl[63:32], a};
      3'd6: return ACC ? hl + sp : hl;
      default: return ACC ? hl - sp : hl;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corner[5];
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (bus.Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("done_hi", {32'h0, bus.HI}, {32'h0, e[63:32]});
        check("done_lo", {32'h0, bus.LO}, {32'h0, e[31:0]});
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    if (n >= 100) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  // Issue one op from an idle DUT, track it in the scoreboard, check latency.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] nx;
    int n;
    nx = model_exec(op, a, b, {m_hi, m_lo});
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    tick();
    bus.Start = 1'b0;
    {m_hi, m_lo} = nx;
    if (is_multi(op)) begin
      exp_q.push_back(nx);
      n = 0;
      while (bus.Busy === 1'b1 && n < 100) begin
        n++;
        tick();
      end
      check("busy_cycles", 64'(n), 64'd33);
      check("done_after_busy", {63'h0, bus.Done}, 64'd1);
    end else begin
      check("busy_single", {63'h0, bus.Busy}, 64'd0);
      check("done_single", {63'h0, bus.Done}, 64'd0);
      check("hilo_single", {bus.HI, bus.LO}, {m_hi, m_lo});
    end
  endtask

  task automatic start_untracked(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    tick();
    bus.Start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] nx;
    bus.Start = 1'b0; bus.Op = '0; bus.A = '0; bus.B = '0;
    bus.Flush = 1'b0; bus.HiLoRead = 1'b0;
    tick(); tick();
    Rst = 1'b1;
    check("reset_hilo", {bus.HI, bus.LO}, 64'h0);
    check("reset_busy_done", {62'h0, bus.Busy, bus.Done}, 64'h0);

    // Directed vectors
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5);
    run_op(3'd3, 32'd100, 32'd7);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd3, 32'h0000_1234, 32'h0);
    run_op(3'd2, 32'hFFFF_FF00, 32'h0);

    // Stall while busy: HiLoRead plus a second Start raised 5 cycles in.
    nx = model_exec(3'd0, 32'd123, 32'hFFFF_FF00, {m_hi, m_lo});
    start_untracked(3'd0, 32'd123, 32'hFFFF_FF00);
    exp_q.push_back(nx);
    {m_hi, m_lo} = nx;
    repeat (4) tick();
    bus.HiLoRead = 1'b1;
    bus.Start = 1'b1; bus.Op = 3'd1; bus.A = 32'hDEAD_BEEF; bus.B = 32'h0000_0013;
    #1;
    check("stall_raised", {63'h0, bus.Stall}, 64'd1);
    for (int i = 0; i < 100 && bus.Busy === 1'b1; i++) begin
      tick();
      if (bus.Busy === 1'b1) check("stall_hold", {63'h0, bus.Stall}, 64'd1);
    end
    check("stall_clear", {63'h0, bus.Stall}, 64'd0);
    check("stall_done", {63'h0, bus.Done}, 64'd1);
    nx = model_exec(3'd1, 32'hDEAD_BEEF, 32'h0000_0013, {m_hi, m_lo});
    tick();
    bus.Start = 1'b0; bus.HiLoRead = 1'b0;
    check("second_accepted", {63'h0, bus.Busy}, 64'd1);
    exp_q.push_back(nx);
    {m_hi, m_lo} = nx;
    wait_idle("second_op");
    tick();

    // Flush at cycle 10 of a MULT keeps prior MTHI/MTLO values.
    run_op(3'd4, 32'h0000_AAAA, 32'h0);
    run_op(3'd5, 32'h0000_5555, 32'h0);
    start_untracked(3'd0, 32'h0000_0777, 32'h0000_0999);
    repeat (9) tick();
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    check("flush_busy", {63'h0, bus.Busy}, 64'd0);
    check("flush_hilo", {bus.HI, bus.LO}, {32'h0000_AAAA, 32'h0000_5555});

    // Flush coinciding with the FIXUP edge wins.
    start_untracked(3'd3, 32'd1000, 32'd3);
    repeat (32) tick();
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    check("flush_fixup_busy_done", {62'h0, bus.Busy, bus.Done}, 64'd0);
    check("flush_fixup_hilo", {bus.HI, bus.LO}, {m_hi, m_lo});

    // Flush together with Start in IDLE: not accepted.
    bus.Flush = 1'b1;
    start_untracked(3'd4, 32'h1357_9BDF, 32'h0);
    start_untracked(3'd0, 32'd3, 32'd3);
    bus.Flush = 1'b0;
    check("flush_start_busy", {63'h0, bus.Busy}, 64'd0);
    check("flush_start_hilo", {bus.HI, bus.LO}, {m_hi, m_lo});

    // Accumulate ops (or their rejection when the feature is absent).
    run_op(3'd4, 32'h0, 32'h0);
    run_op(3'd5, 32'hFFFF_FFFF, 32'h0);
    run_op(3'd6, 32'd1, 32'd1);
    run_op(3'd7, 32'd1, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(op, a, b);
    end
    tick();

    // Reset mid-operation aborts with no write.
    start_untracked(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (3) tick();
    Rst = 1'b0;
    tick(); tick();
    check("rst_hilo", {bus.HI, bus.LO}, 64'h0);
    check("rst_busy_done", {62'h0, bus.Busy, bus.Done}, 64'h0);
    Rst = 1'b1;
    m_hi = '0; m_lo = '0;
    run_op(3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFE);
    tick(); tick();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit for the EX stage, sitting beside the ALU; it owns the HI and LO architectural registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID/EX and computes over multiple cycles.
- Asserts Stall back to the IF/ID and ID/EX registers while a result is pending.
- Supplies HI/LO to the writeback select path for MFHI/MFLO.

Parameters:
- DATA_W, 32, operand width; iteration count = DATA_W, multi-cycle op latency = DATA_W+1 cycles.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset, synchronous, active-low (Rst=0 at a rising edge resets).
- Start  in  1  op request valid from ID/EX.
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- A  in  DATA_W  rs operand (multiplicand / dividend / MTHI/MTLO source).
- B  in  DATA_W  rt operand (multiplier / divisor).
- Flush  in  1  kill the in-flight op (branch/jump squash).
- HiLoRead  in  1  ID holds an MFHI/MFLO.
- Busy  out  1  multi-cycle op in progress.
- Stall  out  1  = Busy & (HiLoRead | Start).
- Done  out  1  one-cycle pulse when HI/LO are updated by a multi-cycle op.
- HI  out  DATA_W  HI register.
- LO  out  DATA_W  LO register.

Behaviour:
- Reset (Rst=0 at edge): HI=0, LO=0, Busy=0, Done=0, FSM=IDLE; any op in flight is aborted with no HI/LO write.
- States: IDLE, MUL, DIV, FIXUP.
- Accept at edge E0 when state=IDLE, Start=1, Flush=0, Rst=1. Start while Busy is not accepted; Stall holds the request upstream until it can be accepted.
- MTHI/MTLO: HI/LO=A at E0. Single cycle, Busy stays 0, no Done pulse.
- MULT/MULTU/DIV/DIVU (and MADD/MSUB when enabled): at E0, latch operands, take absolute values when the op is signed, record result signs, clear the iteration counter, go to MUL or DIV, Busy=1.
- MUL: one shift-add step per edge E1..E32; counter reaches DATA_W, then go to FIXUP.
- DIV: one restoring shift-subtract step per edge E1..E32, then go to FIXUP.
- FIXUP, edge E33:
  - Apply sign correction.
  - Multiply: {HI,LO}=64-bit product.
  - Divide: LO=quotient, HI=remainder.
  - Busy=0, Done=1 for exactly the cycle after E33, state=IDLE.
  - MFHI/MFLO in that cycle reads the new values.
- Signed divide rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0, signed or unsigned): completes with normal latency; LO=0xFFFFFFFF, HI=A.
- Flush=1 at any edge while Busy: return to IDLE, Busy=0, no Done pulse, HI/LO unchanged.
- Flush=1 together with Start in IDLE: the request is not accepted.
- Flush and FIXUP in the same edge: Flush wins, no write.
- Rst=0 has priority over Flush, which has priority over Start.
- Stall is combinational from Busy, HiLoRead and Start. With Busy=0, Stall=0.

Optional Feature:
- Macro: HILO_ACC_EN.
- Defined: Op 110 (MADD) and 111 (MSUB) run the signed multiply path; at FIXUP, {HI,LO} = {HI,LO} ± product, modulo 2^64, same latency.
- Undefined: Op 110/111 are ignored (not accepted, no Busy, no state change), and the accumulate adder is not synthesised.

Test Plan:
- Reset: Rst=0 for 2 cycles after arbitrary activity -> HI=0, LO=0, Busy=0, Done=0.
- MULT A=0xFFFFFFFD (-3), B=5 -> Busy for 33 cycles, Done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- DIVU A=100, B=7 -> LO=14, HI=2. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
- Divide by zero: DIVU A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234.
- Hazards:
  - HiLoRead=1 and a second Start raised 5 cycles into a MULT -> Stall=1 until Done; second Start accepted the cycle Busy drops.
  - Flush at cycle 10 -> Busy=0 next cycle, HI/LO keep the prior MTHI/MTLO values 0xAAAA/0x5555.
- With HILO_ACC_EN: MTHI 0, MTLO 0xFFFFFFFF, MADD 1*1 -> HI=1, LO=0; then MSUB 1*1 -> HI=0, LO=0xFFFFFFFF. Without HILO_ACC_EN: Op=110 -> Busy stays 0, HI/LO unchanged.
